// File: rtl/ex2mem_stage.sv
// ---------------------------------------------------------------------------
// ex2mem_stage
//
// Pipeline register between the execute and memory stages. It also produces
// the ex2mem end of the execute-stage forwarding path, and it detects
// load-use hazards against the instruction it currently holds.
//
// Each rising edge, in priority order:
//   flush      -> bubble (all fields cleared)
//   mem stall  -> hold every field
//   load-use   -> bubble (the load moves on to mem2wb; the consumer re-executes
//                 and then forwards from mem2wb instead)
//   otherwise  -> capture the execute-stage inputs
//
// Optional feature macro: EX2MEM_PERF_CNT_EN
//   When defined, ex2mem_stall_cnt_o is present. It is a 64-bit count of the
//   edges on which a load-use bubble was actually inserted.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   ex2mem_valid_i            execute stage holds a real instruction
//   ex2mem_rd_en_i            instruction writes rd
//   ex2mem_rd_index_i [4:0]   destination register index
//   ex2mem_rd_data_i  [63:0]  ALU result or effective address
//   ex2mem_rs2_data_i [63:0]  store data
//   ex2mem_mem_read_i         instruction is a load
//   ex2mem_mem_write_i        instruction is a store
//   ex2mem_inst_addr_i [63:0] PC of the instruction
//   ex2mem_rs1_src_ex2mem_i   execute stage takes rs1 from this forward
//   ex2mem_rs2_src_ex2mem_i   execute stage takes rs2 from this forward
//   ex2mem_mem_stall_i        memory stage busy; hold the register
//   ex2mem_flush_i            kill the contents
//   ex2mem_*_o                registered copies (flags gated by valid)
//   ex2mem_load_use_stall_o   combinational stall request to IF/ID/EX
//   ex2mem_stall_cnt_o [63:0] load-use bubble count (EX2MEM_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module ex2mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex2mem_valid_i,
  input  logic        ex2mem_rd_en_i,
  input  logic [4:0]  ex2mem_rd_index_i,
  input  logic [63:0] ex2mem_rd_data_i,
  input  logic [63:0] ex2mem_rs2_data_i,
  input  logic        ex2mem_mem_read_i,
  input  logic        ex2mem_mem_write_i,
  input  logic [63:0] ex2mem_inst_addr_i,
  input  logic        ex2mem_rs1_src_ex2mem_i,
  input  logic        ex2mem_rs2_src_ex2mem_i,
  input  logic        ex2mem_mem_stall_i,
  input  logic        ex2mem_flush_i,
  output logic        ex2mem_valid_o,
  output logic        ex2mem_rd_en_o,
  output logic [4:0]  ex2mem_rd_index_o,
  output logic [63:0] ex2mem_rd_data_o,
  output logic [63:0] ex2mem_rs2_data_o,
  output logic        ex2mem_mem_read_o,
  output logic        ex2mem_mem_write_o,
  output logic [63:0] ex2mem_inst_addr_o,
  output logic        ex2mem_load_use_stall_o
`ifdef EX2MEM_PERF_CNT_EN
  ,
  output logic [63:0] ex2mem_stall_cnt_o
`endif
);

  logic        valid_q;
  logic        rd_en_q;
  logic [4:0]  rd_index_q;
  logic [63:0] rd_data_q;
  logic [63:0] rs2_data_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [63:0] inst_addr_q;

  logic        load_use_stall;

  // A held load hazards only if the consumer actually selects this forward.
  assign load_use_stall = valid_q & mem_read_q &
                          (ex2mem_rs1_src_ex2mem_i | ex2mem_rs2_src_ex2mem_i);

  // Pipeline register. A write to x0 is captured with rd_en cleared so that
  // it never shows up on the forwarding path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_index_q  <= '0;
      rd_data_q   <= '0;
      rs2_data_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      inst_addr_q <= '0;
    end else if (ex2mem_flush_i) begin
      valid_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_index_q  <= '0;
      rd_data_q   <= '0;
      rs2_data_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      inst_addr_q <= '0;
    end else if (ex2mem_mem_stall_i) begin
      valid_q     <= valid_q;
      rd_en_q     <= rd_en_q;
      rd_index_q  <= rd_index_q;
      rd_data_q   <= rd_data_q;
      rs2_data_q  <= rs2_data_q;
      mem_read_q  <= mem_read_q;
      mem_write_q <= mem_write_q;
      inst_addr_q <= inst_addr_q;
    end else if (load_use_stall) begin
      valid_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_index_q  <= '0;
      rd_data_q   <= '0;
      rs2_data_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      inst_addr_q <= '0;
    end else begin
      valid_q     <= ex2mem_valid_i;
      rd_en_q     <= ex2mem_valid_i & ex2mem_rd_en_i & (ex2mem_rd_index_i != 5'd0);
      rd_index_q  <= ex2mem_rd_index_i;
      rd_data_q   <= ex2mem_rd_data_i;
      rs2_data_q  <= ex2mem_rs2_data_i;
      mem_read_q  <= ex2mem_valid_i & ex2mem_mem_read_i;
      mem_write_q <= ex2mem_valid_i & ex2mem_mem_write_i;
      inst_addr_q <= ex2mem_inst_addr_i;
    end
  end

  assign ex2mem_valid_o          = valid_q;
  assign ex2mem_rd_en_o          = valid_q & rd_en_q;
  assign ex2mem_rd_index_o       = rd_index_q;
  assign ex2mem_rd_data_o        = rd_data_q;
  assign ex2mem_rs2_data_o       = rs2_data_q;
  assign ex2mem_mem_read_o       = valid_q & mem_read_q;
  assign ex2mem_mem_write_o      = valid_q & mem_write_q;
  assign ex2mem_inst_addr_o      = inst_addr_q;
  assign ex2mem_load_use_stall_o = load_use_stall;

`ifdef EX2MEM_PERF_CNT_EN
  logic [63:0] stall_cnt_q;

  // Counts only edges where the load-use bubble is really inserted: a held
  // or flushed register does not count. Wraps naturally at 2^64.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (load_use_stall && !ex2mem_mem_stall_i && !ex2mem_flush_i) begin
      stall_cnt_q <= stall_cnt_q + 64'd1;
    end
  end

  assign ex2mem_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex2mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex2mem_stage
//
// Self-checking bench for ex2mem_stage. A reference model of the stage
// contents is updated on every clock edge from the stage's rules; a compare
// process checks every DUT output against it on each falling edge. Directed
// sequences additionally pin specific outputs to hand-computed literals.
// Build with EX2MEM_PERF_CNT_EN defined to also cover the stall counter.
// ---------------------------------------------------------------------------
module tb_ex2mem_stage;

  logic        clk;
  logic        rst;
  logic        valid_i, rd_en_i, mem_read_i, mem_write_i;
  logic [4:0]  rd_index_i;
  logic [63:0] rd_data_i, rs2_data_i, inst_addr_i;
  logic        rs1_src_i, rs2_src_i, mem_stall_i, flush_i;

  logic        valid_o, rd_en_o, mem_read_o, mem_write_o, stall_o;
  logic [4:0]  rd_index_o;
  logic [63:0] rd_data_o, rs2_data_o, inst_addr_o;
`ifdef EX2MEM_PERF_CNT_EN
  logic [63:0] stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  ex2mem_stage dut (
    .clk                     (clk),
    .rst                     (rst),
    .ex2mem_valid_i          (valid_i),
    .ex2mem_rd_en_i          (rd_en_i),
    .ex2mem_rd_index_i       (rd_index_i),
    .ex2mem_rd_data_i        (rd_data_i),
    .ex2mem_rs2_data_i       (rs2_data_i),
    .ex2mem_mem_read_i       (mem_read_i),
    .ex2mem_mem_write_i      (mem_write_i),
    .ex2mem_inst_addr_i      (inst_addr_i),
    .ex2mem_rs1_src_ex2mem_i (rs1_src_i),
    .ex2mem_rs2_src_ex2mem_i (rs2_src_i),
    .ex2mem_mem_stall_i      (mem_stall_i),
    .ex2mem_flush_i          (flush_i),
    .ex2mem_valid_o          (valid_o),
    .ex2mem_rd_en_o          (rd_en_o),
    .ex2mem_rd_index_o       (rd_index_o),
    .ex2mem_rd_data_o        (rd_data_o),
    .ex2mem_rs2_data_o       (rs2_data_o),
    .ex2mem_mem_read_o       (mem_read_o),
    .ex2mem_mem_write_o      (mem_write_o),
    .ex2mem_inst_addr_o      (inst_addr_o),
    .ex2mem_load_use_stall_o (stall_o)
`ifdef EX2MEM_PERF_CNT_EN
    ,
    .ex2mem_stall_cnt_o      (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the stage holds, described as an instruction record.
  typedef struct {
    bit          v;
    bit          writes_rd;
    bit [4:0]    idx;
    bit [63:0]   result;
    bit [63:0]   store_data;
    bit          is_load;
    bit          is_store;
    bit [63:0]   pc;
  } instr_t;

  instr_t      held;
  longint unsigned bubbles_inserted;

  function automatic instr_t empty_slot();
    instr_t e;
    e = '{v: 0, writes_rd: 0, idx: 0, result: 0, store_data: 0,
          is_load: 0, is_store: 0, pc: 0};
    return e;
  endfunction

  function automatic bit consumer_needs_held_load(instr_t h, bit s1, bit s2);
    return h.v && h.is_load && (s1 || s2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      held = empty_slot();
      bubbles_inserted = 0;
    end else begin
      bit hazard;
      instr_t incoming;
      hazard = consumer_needs_held_load(held, rs1_src_i, rs2_src_i);
      incoming.v          = valid_i;
      incoming.writes_rd  = valid_i && rd_en_i && (rd_index_i != 0);
      incoming.idx        = rd_index_i;
      incoming.result     = rd_data_i;
      incoming.store_data = rs2_data_i;
      incoming.is_load    = valid_i && mem_read_i;
      incoming.is_store   = valid_i && mem_write_i;
      incoming.pc         = inst_addr_i;
      if (hazard && !mem_stall_i && !flush_i) bubbles_inserted++;
      if (flush_i)          held = empty_slot();
      else if (mem_stall_i) held = held;
      else if (hazard)      held = empty_slot();
      else                  held = incoming;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge the outputs must match the model.
  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      checkOutput("cmp_valid", {63'd0, valid_o}, {63'd0, held.v});
      checkOutput("cmp_rd_en", {63'd0, rd_en_o}, {63'd0, held.writes_rd});
      checkOutput("cmp_mem_read", {63'd0, mem_read_o}, {63'd0, held.is_load});
      checkOutput("cmp_mem_write", {63'd0, mem_write_o}, {63'd0, held.is_store});
      checkOutput("cmp_rd_data", rd_data_o, held.result);
      checkOutput("cmp_rs2_data", rs2_data_o, held.store_data);
      if (held.v) begin
        checkOutput("cmp_rd_index", {59'd0, rd_index_o}, {59'd0, held.idx});
        checkOutput("cmp_inst_addr", inst_addr_o, held.pc);
      end
      checkOutput("cmp_stall", {63'd0, stall_o},
                  {63'd0, consumer_needs_held_load(held, rs1_src_i, rs2_src_i)});
`ifdef EX2MEM_PERF_CNT_EN
      checkOutput("cmp_stall_cnt", stall_cnt_o, bubbles_inserted);
`endif
    end
  end

  // Drive one cycle of inputs shortly after a rising edge.
  task automatic applyStimulus(input logic v, input logic en, input logic [4:0] idx,
                               input logic [63:0] d, input logic [63:0] s2,
                               input logic mr, input logic mw, input logic [63:0] pc,
                               input logic s1src, input logic s2src,
                               input logic ms, input logic fl);
    @(posedge clk);
    #1;
    valid_i = v; rd_en_i = en; rd_index_i = idx; rd_data_i = d; rs2_data_i = s2;
    mem_read_i = mr; mem_write_i = mw; inst_addr_i = pc;
    rs1_src_i = s1src; rs2_src_i = s2src; mem_stall_i = ms; flush_i = fl;
  endtask

  task automatic idle(input logic s1src, input logic ms);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, s1src, 0, ms, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    valid_i = 0; rd_en_i = 0; rd_index_i = 0; rd_data_i = 0; rs2_data_i = 0;
    mem_read_i = 0; mem_write_i = 0; inst_addr_i = 0;
    rs1_src_i = 0; rs2_src_i = 0; mem_stall_i = 0; flush_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_on = 1;
    #1;
    checkOutput("reset_valid", {63'd0, valid_o}, 64'd0);
    checkOutput("reset_rd_data", rd_data_o, 64'd0);
    checkOutput("reset_stall", {63'd0, stall_o}, 64'd0);

    // Pass-through ALU op
    applyStimulus(1, 1, 5, 64'h1234, 64'h0, 0, 0, 64'h1000, 0, 0, 0, 0);
    idle(0, 0);
    #1;
    checkOutput("pass_valid", {63'd0, valid_o}, 64'd1);
    checkOutput("pass_rd_en", {63'd0, rd_en_o}, 64'd1);
    checkOutput("pass_rd_index", {59'd0, rd_index_o}, 64'd5);
    checkOutput("pass_rd_data", rd_data_o, 64'h1234);
    checkOutput("pass_stall", {63'd0, stall_o}, 64'd0);

    // Load-use: load to x7 then a consumer selecting the ex2mem forward
    applyStimulus(1, 1, 7, 64'h8000, 64'h0, 1, 0, 64'h1004, 0, 0, 0, 0);
    applyStimulus(1, 1, 8, 64'h1, 64'h0, 0, 0, 64'h1008, 1, 0, 0, 0);
    #1;
    checkOutput("lu_stall_on", {63'd0, stall_o}, 64'd1);
    checkOutput("lu_mem_read", {63'd0, mem_read_o}, 64'd1);
    applyStimulus(1, 1, 8, 64'h1, 64'h0, 0, 0, 64'h1008, 0, 0, 0, 0);
    #1;
    checkOutput("lu_bubble_valid", {63'd0, valid_o}, 64'd0);
    checkOutput("lu_stall_off", {63'd0, stall_o}, 64'd0);
`ifdef EX2MEM_PERF_CNT_EN
    checkOutput("lu_cnt", stall_cnt_o, 64'd1);
`endif

    // Memory hold over a pending load-use for three edges
    applyStimulus(1, 1, 9, 64'h9000, 64'h0, 1, 0, 64'h100c, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 12, 64'hdead, 64'hbeef, 0, 1, 64'h2000 + i, 1, 0, 1, 0);
      #1;
      checkOutput("hold_rd_index", {59'd0, rd_index_o}, 64'd9);
      checkOutput("hold_rd_data", rd_data_o, 64'h9000);
      checkOutput("hold_stall", {63'd0, stall_o}, 64'd1);
    end
    applyStimulus(1, 1, 12, 64'hdead, 64'hbeef, 0, 1, 64'h2010, 0, 1, 0, 0);
    #1;
    checkOutput("hold_last_pc", inst_addr_o, 64'h100c);
    checkOutput("hold_last_stall", {63'd0, stall_o}, 64'd1);
`ifdef EX2MEM_PERF_CNT_EN
    checkOutput("hold_cnt", stall_cnt_o, 64'd1);
`endif
    idle(0, 0);
    #1;
    checkOutput("hold_bubble_valid", {63'd0, valid_o}, 64'd0);

    // Flush wins over a pending load-use
    applyStimulus(1, 1, 3, 64'h3000, 64'h0, 1, 0, 64'h1010, 0, 0, 0, 0);
    applyStimulus(1, 1, 4, 64'h4444, 64'h0, 0, 0, 64'h1014, 1, 0, 0, 1);
    #1;
    checkOutput("flush_pre_stall", {63'd0, stall_o}, 64'd1);
    idle(0, 0);
    #1;
    checkOutput("flush_valid", {63'd0, valid_o}, 64'd0);
    checkOutput("flush_rd_en", {63'd0, rd_en_o}, 64'd0);
    checkOutput("flush_mem_read", {63'd0, mem_read_o}, 64'd0);
`ifdef EX2MEM_PERF_CNT_EN
    checkOutput("flush_cnt", stall_cnt_o, 64'd2);
`endif

    // x0 destination never forwarded
    applyStimulus(1, 1, 0, 64'hAA, 64'h0, 0, 0, 64'h1018, 0, 0, 0, 0);
    idle(0, 0);
    #1;
    checkOutput("x0_valid", {63'd0, valid_o}, 64'd1);
    checkOutput("x0_rd_en", {63'd0, rd_en_o}, 64'd0);
    checkOutput("x0_rd_data", rd_data_o, 64'hAA);

    // Store capture, then invalid instruction with flags set is gated
    applyStimulus(1, 0, 0, 64'h5008, 64'hcafe_f00d, 0, 1, 64'h101c, 0, 0, 0, 0);
    applyStimulus(0, 1, 6, 64'h77, 64'h0, 1, 1, 64'h1020, 0, 0, 0, 0);
    #1;
    checkOutput("store_mem_write", {63'd0, mem_write_o}, 64'd1);
    checkOutput("store_rs2_data", rs2_data_o, 64'hcafe_f00d);
    applyStimulus(0, 0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 1, 1, 0, 0);
    #1;
    checkOutput("inv_rd_en", {63'd0, rd_en_o}, 64'd0);
    checkOutput("inv_mem_read", {63'd0, mem_read_o}, 64'd0);
    checkOutput("inv_stall", {63'd0, stall_o}, 64'd0);

    // Asynchronous reset during a hold
    applyStimulus(1, 1, 10, 64'h55, 64'h66, 1, 0, 64'h1024, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 0, 1, 1, 0);
    #1;
    checkOutput("prerst_valid", {63'd0, valid_o}, 64'd1);
    checkOutput("prerst_stall", {63'd0, stall_o}, 64'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_valid", {63'd0, valid_o}, 64'd0);
    checkOutput("arst_rd_data", rd_data_o, 64'd0);
    checkOutput("arst_rs2_data", rs2_data_o, 64'd0);
    checkOutput("arst_pc", inst_addr_o, 64'd0);
    checkOutput("arst_stall", {63'd0, stall_o}, 64'd0);
`ifdef EX2MEM_PERF_CNT_EN
    checkOutput("arst_cnt", stall_cnt_o, 64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    idle(0, 0);
    idle(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
